// File: rtl/pcie_link_channel.sv
// Serial-link channel model sitting between one PcieVhost's LinkOut lanes and
// its peer's LinkIn lanes. Adds programmable per-lane skew, lane reversal,
// per-lane polarity inversion, periodic error injection and a link-stall
// watchdog. Instantiate once per direction.
module pcie_link_channel #(
  parameter  int NUM_LANES = 16,
  parameter  int MAX_SKEW  = 8,
  localparam int SKEW_W    = $clog2(MAX_SKEW)
) (
  input  logic                        Clk,
  input  logic                        notReset,
  input  logic [NUM_LANES*10-1:0]     LinkIn,
  output logic [NUM_LANES*10-1:0]     LinkOut,
  input  logic [NUM_LANES*SKEW_W-1:0] LaneSkew,
  input  logic [NUM_LANES-1:0]        InvertPolarity,
  input  logic                        ReverseLanes,
  input  logic                        ErrInjEn,
  input  logic [15:0]                 ErrInjPeriod,
  input  logic [7:0]                  ErrInjLane,
  input  logic [9:0]                  ErrInjMask,
  output logic [15:0]                 ErrInjCount,
  input  logic [31:0]                 IdleTimeout,
  output logic                        TimedOut
);

  localparam int         LINK_W     = NUM_LANES * 10;
  localparam logic [8:0] LANE_LIMIT = 9'(NUM_LANES);

  // Skewed symbol per input lane, before reversal / inversion / corruption
  logic [9:0]        skewed [NUM_LANES];
  // Fully impaired symbols, registered into LinkOut on the next edge
  logic [LINK_W-1:0] link_out_next;
  logic [LINK_W-1:0] link_out_reg;

  // Error injection state
  logic              inj_active;
  logic              inj_fire;
  logic              inj_lane_valid;
  logic [15:0]       inj_cnt_reg;
  logic [15:0]       inj_cnt_next;
  logic [15:0]       err_count_reg;

  // Watchdog state
  logic [LINK_W-1:0] prev_in_reg;
  logic [31:0]       idle_cnt_reg;
  logic [31:0]       idle_cnt_next;
  logic              timed_out_reg;

  // ---------------------------------------------------------------------------
  // Per-input-lane delay line and skew tap
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_skew
      logic [9:0]        dly_reg [MAX_SKEW];
      logic [SKEW_W-1:0] skew;
      logic [SKEW_W-1:0] tap;

      assign skew = LaneSkew[gi*SKEW_W +: SKEW_W];
      // Stage k holds the symbol seen k+1 cycles ago, so skew N taps stage N-1
      assign tap  = skew - 1'b1;

      // Shift the lane's symbol history every cycle; reset flushes it
      always_ff @(posedge Clk or negedge notReset) begin
        if (!notReset) begin
          for (int k = 0; k < MAX_SKEW; k++) begin
            dly_reg[k] <= '0;
          end
        end else begin
          dly_reg[0] <= LinkIn[gi*10 +: 10];
          for (int k = 1; k < MAX_SKEW; k++) begin
            dly_reg[k] <= dly_reg[k-1];
          end
        end
      end

      assign skewed[gi] = (skew == '0) ? LinkIn[gi*10 +: 10] : dly_reg[tap];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Per-output-lane reversal, polarity inversion and error corruption
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_out
      localparam int REV_SRC = NUM_LANES - 1 - gi;
      logic [9:0] v_sel;
      logic [9:0] v_pol;
      logic       hit;

      assign v_sel = ReverseLanes ? skewed[REV_SRC] : skewed[gi];
      assign v_pol = InvertPolarity[gi] ? ~v_sel : v_sel;
      assign hit   = inj_fire && (ErrInjLane == 8'(gi));
      assign link_out_next[gi*10 +: 10] = hit ? (v_pol ^ ErrInjMask) : v_pol;
    end
  endgenerate

  // Register the impaired symbols so every lane sees one cycle of base latency
  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) begin
      link_out_reg <= '0;
    end else begin
      link_out_reg <= link_out_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Periodic error injection
  // ---------------------------------------------------------------------------
  assign inj_active     = ErrInjEn && (ErrInjPeriod != 16'd0);
  // A shrunk period can leave the counter above the target; it then wraps
  // through 16-bit overflow before the next fire, which is acceptable.
  assign inj_fire       = inj_active && (inj_cnt_reg == (ErrInjPeriod - 16'd1));
  // Out-of-range target lanes corrupt nothing and therefore are not counted
  assign inj_lane_valid = ({1'b0, ErrInjLane} < LANE_LIMIT);

  // Next injection counter value: held at zero when idle, restarts after a fire
  always_comb begin
    inj_cnt_next = inj_cnt_reg + 16'd1;
    if (!inj_active || inj_fire) begin
      inj_cnt_next = 16'd0;
    end
  end

  // Injection counter and saturating count of effective injections
  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) begin
      inj_cnt_reg   <= '0;
      err_count_reg <= '0;
    end else begin
      inj_cnt_reg <= inj_cnt_next;
      if (inj_fire && inj_lane_valid && (err_count_reg != 16'hFFFF)) begin
        err_count_reg <= err_count_reg + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Link-stall watchdog
  // ---------------------------------------------------------------------------
  // Idle run length: restarts on any input change, saturates when stalled forever
  always_comb begin
    idle_cnt_next = idle_cnt_reg;
    if (LinkIn != prev_in_reg) begin
      idle_cnt_next = 32'd0;
    end else if (idle_cnt_reg != 32'hFFFF_FFFF) begin
      idle_cnt_next = idle_cnt_reg + 32'd1;
    end
  end

  // Track previous input, idle length and the sticky timeout flag
  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) begin
      prev_in_reg   <= '0;
      idle_cnt_reg  <= '0;
      timed_out_reg <= 1'b0;
    end else begin
      prev_in_reg  <= LinkIn;
      idle_cnt_reg <= idle_cnt_next;
      if ((IdleTimeout != 32'd0) && (idle_cnt_reg == IdleTimeout)) begin
        timed_out_reg <= 1'b1;
      end
    end
  end

  assign LinkOut     = link_out_reg;
  assign ErrInjCount = err_count_reg;
  assign TimedOut    = timed_out_reg;

endmodule

// File: tb/tb_pcie_link_channel.sv
// Self-checking bench for pcie_link_channel: randomized lanes checked against a
// history-based reference model (output = impaired input from 1+skew cycles ago).
module tb_pcie_link_channel;

  localparam int NL = 16;
  localparam int MS = 8;
  localparam int SW = 3;
  localparam int LW = NL * 10;

  logic          Clk = 1'b0;
  logic          notReset = 1'b0;
  logic [LW-1:0] LinkIn = '0;
  logic [LW-1:0] LinkOut;
  logic [NL*SW-1:0] LaneSkew = '0;
  logic [NL-1:0] InvertPolarity = '0;
  logic          ReverseLanes = 1'b0;
  logic          ErrInjEn = 1'b0;
  logic [15:0]   ErrInjPeriod = '0;
  logic [7:0]    ErrInjLane = '0;
  logic [9:0]    ErrInjMask = '0;
  logic [15:0]   ErrInjCount;
  logic [31:0]   IdleTimeout = '0;
  logic          TimedOut;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [LW-1:0] hist [$];      // hist[0] = input captured at the latest edge
  int            en_cycles;     // edges since injection was enabled
  logic [15:0]   exp_cnt;
  logic          exp_to;
  logic [31:0]   idle_m;
  logic [LW-1:0] prev_m;
  logic [LW-1:0] exp_out;
  logic          last_fire;

  always #5 Clk = ~Clk;

  pcie_link_channel dut (
    .Clk(Clk), .notReset(notReset), .LinkIn(LinkIn), .LinkOut(LinkOut),
    .LaneSkew(LaneSkew), .InvertPolarity(InvertPolarity), .ReverseLanes(ReverseLanes),
    .ErrInjEn(ErrInjEn), .ErrInjPeriod(ErrInjPeriod), .ErrInjLane(ErrInjLane),
    .ErrInjMask(ErrInjMask), .ErrInjCount(ErrInjCount), .IdleTimeout(IdleTimeout),
    .TimedOut(TimedOut)
  );

  function automatic logic [LW-1:0] rand_link();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_clear();
    hist.delete();
    en_cycles = 0;
    exp_cnt   = '0;
    exp_to    = 1'b0;
    idle_m    = '0;
    prev_m    = '0;
    exp_out   = '0;
    last_fire = 1'b0;
  endtask

  task automatic set_defaults();
    LinkIn = '0; LaneSkew = '0; InvertPolarity = '0; ReverseLanes = 1'b0;
    ErrInjEn = 1'b0; ErrInjPeriod = '0; ErrInjLane = '0; ErrInjMask = '0;
    IdleTimeout = '0;
  endtask

  // Hold reset briefly, clear the model, release on a falling edge
  task automatic apply_reset();
    notReset = 1'b0;
    #3;
    model_clear();
    @(negedge Clk);
    notReset = 1'b1;
  endtask

  // Advance one clock edge, update the model from the inputs seen at that edge,
  // then settle 1 time unit so outputs can be sampled away from the edge.
  task automatic tick();
    logic [LW-1:0] cur;
    logic [LW-1:0] nxt;
    logic [9:0]    v;
    logic          fire;
    int            src;
    int            sk;
    @(posedge Clk);
    cur = LinkIn;
    hist.push_front(cur);
    if (hist.size() > MS + 1) void'(hist.pop_back());
    fire = 1'b0;
    if (ErrInjEn && ErrInjPeriod != 0) begin
      en_cycles++;
      fire = ((en_cycles % int'(ErrInjPeriod)) == 0);
    end else begin
      en_cycles = 0;
    end
    if (fire && ErrInjLane < NL && exp_cnt != 16'hFFFF) exp_cnt++;
    nxt = '0;
    for (int i = 0; i < NL; i++) begin
      src = ReverseLanes ? NL - 1 - i : i;
      sk  = int'(LaneSkew[src*SW +: SW]);
      v   = (sk < hist.size()) ? hist[sk][src*10 +: 10] : 10'h000;
      if (InvertPolarity[i]) v = ~v;
      if (fire && int'(ErrInjLane) == i) v = v ^ ErrInjMask;
      nxt[i*10 +: 10] = v;
    end
    exp_out = nxt;
    if (IdleTimeout != 0 && idle_m == IdleTimeout) exp_to = 1'b1;
    if (cur != prev_m) idle_m = '0;
    else if (idle_m != 32'hFFFF_FFFF) idle_m = idle_m + 1;
    prev_m    = cur;
    last_fire = fire;
    #1;
  endtask

  task automatic test_reset();
    set_defaults();
    notReset = 1'b0;
    #7;
    n_cmp++; if (LinkOut !== '0) begin n_err++; $display("FAIL reset_linkout got=%h exp=0", LinkOut); end
    n_cmp++; if (ErrInjCount !== 16'd0) begin n_err++; $display("FAIL reset_errcnt got=%h exp=0", ErrInjCount); end
    n_cmp++; if (TimedOut !== 1'b0) begin n_err++; $display("FAIL reset_timedout got=%b exp=0", TimedOut); end
    model_clear();
    @(negedge Clk);
    notReset = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_passthrough();
    logic [LW-1:0] drv;
    set_defaults();
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      for (int l = 0; l < NL; l++) drv[l*10 +: 10] = 10'((c*16 + l) & 10'h3FF);
      LinkIn = drv;
      tick();
      n_cmp++; if (LinkOut !== drv) begin n_err++; $display("FAIL pass_out cyc=%0d got=%h exp=%h", c, LinkOut, drv); end
      n_cmp++; if (ErrInjCount !== 16'd0) begin n_err++; $display("FAIL pass_errcnt cyc=%0d got=%h exp=0", c, ErrInjCount); end
      n_cmp++; if (TimedOut !== 1'b0) begin n_err++; $display("FAIL pass_timedout cyc=%0d got=%b exp=0", c, TimedOut); end
    end
    $display("test_passthrough done");
  endtask

  task automatic test_skew();
    logic [9:0] want;
    set_defaults();
    apply_reset();
    LaneSkew[3*SW +: SW] = 3'd5;
    for (int c = 1; c <= 8; c++) begin
      LinkIn = rand_link();
      LinkIn[3*10 +: 10] = (c == 1) ? 10'h17C : 10'h000;
      tick();
      want = (c == 6) ? 10'h17C : 10'h000;
      n_cmp++; if (LinkOut[3*10 +: 10] !== want) begin n_err++; $display("FAIL skew_lane3 cyc=%0d got=%h exp=%h", c, LinkOut[3*10 +: 10], want); end
      n_cmp++; if (LinkOut !== exp_out) begin n_err++; $display("FAIL skew_out cyc=%0d got=%h exp=%h", c, LinkOut, exp_out); end
    end
    $display("test_skew done");
  endtask

  task automatic test_reverse_polarity();
    set_defaults();
    apply_reset();
    ReverseLanes   = 1'b1;
    InvertPolarity = 16'h0001;
    for (int c = 0; c < 6; c++) begin
      LinkIn = rand_link();
      LinkIn[15*10 +: 10] = 10'h0F0;
      tick();
      n_cmp++; if (LinkOut[9:0] !== 10'h30F) begin n_err++; $display("FAIL rev_lane0 cyc=%0d got=%h exp=30f", c, LinkOut[9:0]); end
      n_cmp++; if (LinkOut !== exp_out) begin n_err++; $display("FAIL rev_out cyc=%0d got=%h exp=%h", c, LinkOut, exp_out); end
    end
    $display("test_reverse_polarity done");
  endtask

  task automatic test_err_inj();
    logic [9:0] raw;
    logic [9:0] want;
    set_defaults();
    apply_reset();
    ErrInjEn = 1'b1; ErrInjPeriod = 16'd4; ErrInjLane = 8'd2; ErrInjMask = 10'h001;
    for (int c = 1; c <= 40; c++) begin
      LinkIn = rand_link();
      raw = LinkIn[2*10 +: 10];
      tick();
      want = ((c % 4) == 0) ? 10'h001 : 10'h000;
      n_cmp++; if ((LinkOut[2*10 +: 10] ^ raw) !== want) begin n_err++; $display("FAIL inj_flip cyc=%0d got=%h exp=%h", c, LinkOut[2*10 +: 10] ^ raw, want); end
      n_cmp++; if (LinkOut !== exp_out) begin n_err++; $display("FAIL inj_out cyc=%0d got=%h exp=%h", c, LinkOut, exp_out); end
    end
    n_cmp++; if (ErrInjCount !== 16'd10) begin n_err++; $display("FAIL inj_count got=%0d exp=10", ErrInjCount); end
    $display("test_err_inj done count=%0d", ErrInjCount);
  endtask

  task automatic test_err_inj_oob();
    logic [LW-1:0] drv;
    set_defaults();
    apply_reset();
    ErrInjEn = 1'b1; ErrInjPeriod = 16'd3; ErrInjLane = 8'd20; ErrInjMask = 10'h3FF;
    for (int c = 1; c <= 12; c++) begin
      drv = rand_link();
      LinkIn = drv;
      tick();
      n_cmp++; if (LinkOut !== drv) begin n_err++; $display("FAIL oob_out cyc=%0d got=%h exp=%h", c, LinkOut, drv); end
    end
    n_cmp++; if (ErrInjCount !== 16'd0) begin n_err++; $display("FAIL oob_count got=%0d exp=0", ErrInjCount); end
    $display("test_err_inj_oob done");
  endtask

  task automatic test_watchdog();
    logic [LW-1:0] held;
    set_defaults();
    IdleTimeout = 32'd100;
    apply_reset();
    for (int l = 0; l < NL; l++) held[l*10 +: 10] = 10'h155;
    LinkIn = held;
    // Edge 1 sees a change from the cleared previous input; idle reaches 100
    // after edge 101, so the flag rises on edge 102.
    for (int c = 1; c <= 101; c++) begin
      tick();
      n_cmp++; if (TimedOut !== exp_to) begin n_err++; $display("FAIL wd_model cyc=%0d got=%b exp=%b", c, TimedOut, exp_to); end
    end
    n_cmp++; if (TimedOut !== 1'b0) begin n_err++; $display("FAIL wd_early got=%b exp=0", TimedOut); end
    tick();
    n_cmp++; if (TimedOut !== 1'b1) begin n_err++; $display("FAIL wd_rise got=%b exp=1", TimedOut); end
    for (int c = 0; c < 5; c++) begin
      LinkIn = rand_link();
      tick();
      n_cmp++; if (TimedOut !== 1'b1) begin n_err++; $display("FAIL wd_sticky cyc=%0d got=%b exp=1", c, TimedOut); end
    end
    $display("test_watchdog done");
  endtask

  task automatic test_random();
    set_defaults();
    apply_reset();
    IdleTimeout = 32'd6;
    for (int b = 0; b < 4; b++) begin
      // One disabled cycle so a new period starts from a clean counter
      ErrInjEn = 1'b0;
      tick();
      ErrInjEn     = 1'b1;
      ErrInjPeriod = 16'($urandom_range(1, 7));
      ErrInjLane   = 8'($urandom_range(0, 17));
      ErrInjMask   = 10'($urandom);
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(0, 9) < 7) LinkIn = rand_link();
        LaneSkew       = {$urandom, $urandom};
        InvertPolarity = 16'($urandom);
        ReverseLanes   = 1'($urandom);
        tick();
        n_cmp++; if (LinkOut !== exp_out) begin n_err++; $display("FAIL rnd_out blk=%0d cyc=%0d got=%h exp=%h", b, c, LinkOut, exp_out); end
        n_cmp++; if (ErrInjCount !== exp_cnt) begin n_err++; $display("FAIL rnd_count blk=%0d cyc=%0d got=%0d exp=%0d", b, c, ErrInjCount, exp_cnt); end
        n_cmp++; if (TimedOut !== exp_to) begin n_err++; $display("FAIL rnd_timedout blk=%0d cyc=%0d got=%b exp=%b", b, c, TimedOut, exp_to); end
      end
      $display("test_random block %0d period=%0d lane=%0d count=%0d", b, ErrInjPeriod, ErrInjLane, ErrInjCount);
    end
  endtask

  task automatic test_mid_reset();
    set_defaults();
    apply_reset();
    IdleTimeout = 32'd3;
    ErrInjEn = 1'b1; ErrInjPeriod = 16'd2; ErrInjLane = 8'd0; ErrInjMask = 10'h3FF;
    LaneSkew = '1;
    LinkIn = rand_link();
    for (int c = 0; c < 10; c++) tick();
    n_cmp++; if (TimedOut !== exp_to) begin n_err++; $display("FAIL mid_pre_to got=%b exp=%b", TimedOut, exp_to); end
    n_cmp++; if (ErrInjCount !== exp_cnt) begin n_err++; $display("FAIL mid_pre_count got=%0d exp=%0d", ErrInjCount, exp_cnt); end
    notReset = 1'b0;
    #3;
    n_cmp++; if (LinkOut !== '0) begin n_err++; $display("FAIL mid_linkout got=%h exp=0", LinkOut); end
    n_cmp++; if (ErrInjCount !== 16'd0) begin n_err++; $display("FAIL mid_count got=%0d exp=0", ErrInjCount); end
    n_cmp++; if (TimedOut !== 1'b0) begin n_err++; $display("FAIL mid_timedout got=%b exp=0", TimedOut); end
    model_clear();
    @(negedge Clk);
    notReset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      LinkIn = rand_link();
      tick();
      n_cmp++; if (LinkOut !== exp_out) begin n_err++; $display("FAIL mid_post_out cyc=%0d got=%h exp=%h", c, LinkOut, exp_out); end
      n_cmp++; if (ErrInjCount !== exp_cnt) begin n_err++; $display("FAIL mid_post_count cyc=%0d got=%0d exp=%0d", c, ErrInjCount, exp_cnt); end
    end
    $display("test_mid_reset done");
  endtask

  initial begin
    model_clear();
    test_reset();
    test_passthrough();
    test_skew();
    test_reverse_polarity();
    test_err_inj();
    test_err_inj_oob();
    test_watchdog();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
